// File: rtl/sb_drain_unit.sv
// rtl/sb_drain_unit.sv - drains committed store buffer entries to the memory write port
module sb_drain_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                sb_valid_i,
    output logic                sb_ready_o,
    input  logic [ADDR_W-1:0]   sb_addr_i,
    input  logic [DATA_W-1:0]   sb_data_i,
    input  logic [DATA_W/8-1:0] sb_strb_i,
    output logic                wr_valid_o,
    input  logic                wr_ready_i,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic [DATA_W/8-1:0] wr_strb_o,
    input  logic                wr_resp_valid_i,
    input  logic                wr_resp_err_i,
    output logic                idle_o,
    output logic                err_o,
    output logic [ADDR_W-1:0]   err_addr_o,
    output logic [CNT_W-1:0]    drained_cnt_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pop;

    always_comb begin
        state_d    = state_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        drop_d     = drop_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sb_valid_i && !flush_i) begin
                    if (sb_strb_i != '0) begin
                        wr_addr_d  = sb_addr_i;
                        wr_data_d  = sb_data_i;
                        wr_strb_d  = sb_strb_i;
                        wr_valid_d = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (flush_i) drop_d = 1'b1;
                if (wr_ready_i) begin
                    wr_valid_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) drop_d = 1'b1;
                if (wr_resp_valid_i) begin
                    // A flushed entry is gone from the store buffer; consume the response only.
                    pop = !drop_q && !flush_i;
                    if (wr_resp_err_i) begin
                        err_d = 1'b1;
                        if (!err_q) err_addr_d = wr_addr_q;
                    end
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    // A response with no outstanding request indicates a broken bus agent.
    always @(posedge clk) begin
        if (rst_n && state_q != S_WAIT) assert (!wr_resp_valid_i);
    end

    assign sb_ready_o    = pop;
    assign wr_valid_o    = wr_valid_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign wr_strb_o     = wr_strb_q;
    assign idle_o        = (state_q == S_IDLE) && !drop_q;
    assign err_o         = err_q;
    assign err_addr_o    = err_addr_q;
    assign drained_cnt_o = cnt_q;
endmodule

// File: tb/tb_sb_drain_unit.sv
// tb/tb_sb_drain_unit.sv - directed and randomized bench for sb_drain_unit
module tb_sb_drain_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        sb_valid_i = 1'b0;
    logic        sb_ready_o;
    logic [31:0] sb_addr_i = '0;
    logic [31:0] sb_data_i = '0;
    logic [3:0]  sb_strb_i = '0;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b0;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;
    logic        wr_resp_valid_i = 1'b0;
    logic        wr_resp_err_i = 1'b0;
    logic        idle_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic [3:0]  drained_cnt_o;

    sb_drain_unit #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .sb_valid_i(sb_valid_i), .sb_ready_o(sb_ready_o),
        .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i), .sb_strb_i(sb_strb_i),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
        .wr_resp_valid_i(wr_resp_valid_i), .wr_resp_err_i(wr_resp_err_i),
        .idle_o(idle_o), .err_o(err_o), .err_addr_o(err_addr_o),
        .drained_cnt_o(drained_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [3:0]  cnt_m = '0;
    logic        err_m = 1'b0;
    logic [31:0] eaddr_m = '0;
    int          last_pop = -100;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("idle", idle_o, 1'b1);
        chk("cnt", drained_cnt_o, cnt_m);
        chk("err", err_o, err_m);
        chk("err_addr", err_addr_o, eaddr_m);
    endtask

    // One store from the head of the buffer; flush_k counts cycles after issue (-1 = none).
    task automatic drain_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int rdly, input int rsp_dly, input int flush_k, input bit err);
        int k;
        bit dropped;
        k = 0;
        dropped = 1'b0;
        @(negedge clk);
        sb_valid_i = 1'b1; sb_addr_i = a; sb_data_i = d; sb_strb_i = s;
        #1;
        if (s == 4'h0) begin
            chk("zs_pop", sb_ready_o, 1'b1);
            chk("zs_wv", wr_valid_o, 1'b0);
            @(posedge clk); #1;
            cnt_m = cnt_m + 1'b1;
            sb_valid_i = 1'b0;
            check_state();
            return;
        end
        chk("issue_nopop", sb_ready_o, 1'b0);
        @(posedge clk);
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk);
            wr_ready_i = (i == rdly);
            flush_i = (k == flush_k);
            if (flush_i) begin dropped = 1'b1; sb_valid_i = 1'b0; end
            #1;
            chk("req_valid", wr_valid_o, 1'b1);
            chk("req_addr", wr_addr_o, a);
            chk("req_data", wr_data_o, d);
            chk("req_strb", wr_strb_o, s);
            chk("req_nopop", sb_ready_o, 1'b0);
            @(posedge clk);
            k++;
        end
        for (int i = 0; i <= rsp_dly; i++) begin
            @(negedge clk);
            wr_ready_i = 1'b0;
            flush_i = (k == flush_k);
            if (flush_i) begin dropped = 1'b1; sb_valid_i = 1'b0; end
            wr_resp_valid_i = (i == rsp_dly);
            wr_resp_err_i = err && (i == rsp_dly);
            #1;
            chk("wait_wv", wr_valid_o, 1'b0);
            chk("wait_pop", sb_ready_o, (i == rsp_dly) && !dropped);
            if (i == rsp_dly && !dropped) begin
                if (cyc - last_pop < 3) chk("pop_spacing", cyc - last_pop, 3);
                last_pop = cyc;
            end
            @(posedge clk);
            k++;
        end
        #1;
        wr_resp_valid_i = 1'b0; wr_resp_err_i = 1'b0; flush_i = 1'b0; sb_valid_i = 1'b0;
        if (!dropped) cnt_m = cnt_m + 1'b1;
        if (err && !err_m) begin err_m = 1'b1; eaddr_m = a; end
        check_state();
    endtask

    initial begin
        int rd, rs, fk;
        logic [3:0] s;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wv", wr_valid_o, 1'b0);
        chk("rst_addr", wr_addr_o, 32'h0);
        chk("rst_data", wr_data_o, 32'h0);
        chk("rst_strb", wr_strb_o, 4'h0);
        chk("rst_pop", sb_ready_o, 1'b0);
        check_state();
        rst_n = 1'b1;

        drain_one(32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, -1, 1'b0);
        drain_one(32'h1004, 32'h12345678, 4'h3, 5, 0, -1, 1'b0);
        drain_one(32'h1008, 32'hCAFEF00D, 4'hC, 0, 3, 1, 1'b0);
        drain_one(32'h100C, 32'h0BADCAFE, 4'h1, 0, 0, -1, 1'b0);
        drain_one(32'h1010, 32'h55555555, 4'h0, 0, 0, -1, 1'b0);
        drain_one(32'h1014, 32'hAAAAAAAA, 4'h6, 2, 1, 0, 1'b0);

        // A flush in IDLE must neither latch nor pop.
        @(negedge clk);
        sb_valid_i = 1'b1; flush_i = 1'b1; sb_addr_i = 32'h1018; sb_strb_i = 4'hF;
        #1;
        chk("fl_idle_pop", sb_ready_o, 1'b0);
        @(posedge clk); #1;
        chk("fl_idle_wv", wr_valid_o, 1'b0);
        flush_i = 1'b0; sb_valid_i = 1'b0;
        check_state();

        drain_one(32'h2000, 32'h11111111, 4'hF, 1, 1, -1, 1'b1);
        drain_one(32'h3000, 32'h22222222, 4'hF, 0, 2, -1, 1'b1);

        for (int n = 0; n < 150; n++) begin
            rd = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            fk = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rd + rs + 1) : -1;
            s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            drain_one($urandom & 32'hFFFF_FFFC, $urandom, s, rd, rs, fk, $urandom_range(0, 7) == 0);
        end

        // Reset while a request is pending on the bus.
        @(negedge clk);
        sb_valid_i = 1'b1; sb_addr_i = 32'h4000; sb_data_i = 32'h77; sb_strb_i = 4'hF;
        @(posedge clk); #1;
        chk("pre_rst_wv", wr_valid_o, 1'b1);
        rst_n = 1'b0; sb_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_m = '0; err_m = 1'b0; eaddr_m = '0; last_pop = -100;
        chk("rst_req_wv", wr_valid_o, 1'b0);
        check_state();

        for (int n = 0; n < 3; n++)
            drain_one(32'h5000 + 32'(4 * n), 32'(n), 4'hF, 0, 0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
